// File: rtl/sipo_pkg.sv
// Shared types and sizing helpers for the SIPO deframer.
package sipo_pkg;

    typedef enum logic [0:0] {
        HUNT     = 1'b0,
        ASSEMBLE = 1'b1
    } state_e;

    // Bit counter must be able to represent 0..N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// Single-entry valid/ready output register; flags a sticky overflow when a
// new word arrives while the held word is still unconsumed.
module sipo_hold_reg #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [N-1:0] data_i,
    input  logic         out_ready_i,
    input  logic         ovf_clr_i,
    output logic [N-1:0] data_o,
    output logic         valid_o,
    output logic         overflow_o
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         space;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        space   = !valid_q || out_ready_i;
        data_d  = data_q;
        valid_d = valid_q && !out_ready_i;
        ovf_d   = ovf_q;
        if (load_i && space) begin
            data_d  = data_i;
            valid_d = 1'b1;
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end else if (load_i && !space) begin
            ovf_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/sipo_deframer.sv
// LSB-first serial-to-parallel receiver with sync-based framing, resync error
// pulse and a single-entry valid/ready output register.
module sipo_deframer
    import sipo_pkg::*;
#(
    parameter int N        = 8,
    parameter bit FREE_RUN = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sin,
    input  logic         sin_valid,
    input  logic         sin_sync,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         overflow,
    input  logic         ovf_clr,
    output logic         frame_err
);

    localparam int            CW          = cnt_width(N);
    localparam state_e        RESET_STATE = FREE_RUN ? ASSEMBLE : HUNT;
    localparam logic [CW-1:0] LAST_CNT    = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sr_q, sr_d;
    logic          ferr_q, ferr_d;
    logic [N-1:0]  sr_shift;
    logic          complete;

    assign sr_shift = {sin, sr_q[N-1:1]};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sr_d     = sr_q;
        ferr_d   = 1'b0;
        complete = 1'b0;
        if (sin_valid) begin
            // Sync always restarts the word and outranks completion.
            if (sin_sync) begin
                sr_d    = sr_shift;
                cnt_d   = CW'(1);
                state_d = ASSEMBLE;
                ferr_d  = (state_q == ASSEMBLE) && (cnt_q != '0);
            end else if (state_q == ASSEMBLE) begin
                sr_d = sr_shift;
                if (cnt_q == LAST_CNT) begin
                    cnt_d    = '0;
                    complete = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ferr_q  <= ferr_d;
        end
    end

    sipo_hold_reg #(.N(N)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .load_i     (complete),
        .data_i     (sr_shift),
        .out_ready_i(out_ready),
        .ovf_clr_i  (ovf_clr),
        .data_o     (out_data),
        .valid_o    (out_valid),
        .overflow_o (overflow)
    );

    assign frame_err = ferr_q;

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
Serial-in, parallel-out receiver that sits directly downstream of the PISO shifter. It takes an LSB-first serial bit stream, qualified by a valid strobe and a frame-start marker, and assembles N-bit words. Each completed word is presented on a single-entry output register with a valid/ready handshake. Overflow and framing errors are flagged; the block never stalls the serial side.

Parameters:
N, 8, word width in bits (N >= 2)
FREE_RUN, 0, 1 = start assembling immediately after reset without waiting for sin_sync; 0 = hunt for sin_sync first

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
sin  input  1  serial data bit, LSB of word first
sin_valid  input  1  sin is sampled only on cycles where this is 1
sin_sync  input  1  qualified by sin_valid; marks current bit as bit 0 of a new word
out_data  output  N  assembled word, stable while out_valid=1
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts word when out_valid & out_ready
overflow  output  1  sticky: a completed word was dropped because the output register was full
ovf_clr  input  1  synchronous clear of overflow (clear wins over set in the same cycle)
frame_err  output  1  one-cycle pulse: sin_sync arrived while a partial word was in progress

Behaviour:
- Reset (async, rst=1): state=HUNT (ASSEMBLE if FREE_RUN=1), bit_cnt=0, shift reg=0, out_data=0, out_valid=0, overflow=0, frame_err=0. Reset mid-word discards the partial word and any held output word.
- Bit accept: a cycle with sin_valid=1. Cycles with sin_valid=0 change nothing on the serial side; gaps of any length are legal.
- Shift: on accept, sr <= {sin, sr[N-1:1]}. After N accepts, sr[k] = k-th received bit, so the word is LSB-first and mirrors PISO output order.
- States:
  - HUNT: accepts with sin_sync=0 are ignored. An accept with sin_sync=1 shifts the bit, sets bit_cnt=1 and moves to ASSEMBLE.
  - ASSEMBLE, accept with sin_sync=0: shift, bit_cnt++.
  - ASSEMBLE, accept with sin_sync=1 and bit_cnt != 0: discard the partial word, pulse frame_err the next cycle, treat the bit as bit 0 (bit_cnt=1).
  - ASSEMBLE, accept with sin_sync=1 and bit_cnt == 0: normal start, no error.
- Completion: the accept that makes bit_cnt reach N is the completing accept. On that edge bit_cnt wraps to 0, state stays ASSEMBLE, and the next word needs no sync. The completed word is the post-shift value {sin, sr[N-1:1]}.
- Output load on completion:
  - If out_valid=0, or out_valid=1 and out_ready=1 on the same cycle: out_data <= word, out_valid=1 from the next cycle. Latency is 1 cycle after the Nth accepted bit, with no overflow.
  - If out_valid=1 and out_ready=0: the new word is dropped, out_data is unchanged and overflow is set.
- Handshake: a transfer occurs when out_valid & out_ready. Without a new completion, out_valid drops the next cycle. out_data must not change while out_valid=1 && out_ready=0.
- Sync and completion together: a sync on the Nth bit is a resync. The partial word is discarded with frame_err, and the bit is bit 0 of a new word. Sync takes priority over completion.
- bit_cnt width: $clog2(N+1); counts 0..N-1 between accepts.
- No combinational path from sin/sin_valid/sin_sync to any output. out_valid does not depend combinationally on out_ready.

Decomposition:
- Shared package sipo_pkg holds:
  - state enum {HUNT, ASSEMBLE}
  - localparam function for counter width
- One natural sub-module: sipo_hold_reg, the single-entry valid/ready holding register with overflow detect, parameterised on N. Shift register, counter and FSM stay in the top module.

Test Plan:
- N=8, FREE_RUN=0, out_ready=1: sync + bits of 0xA5 LSB-first (1,0,1,0,0,1,0,1) on consecutive cycles -> out_data=0xA5, out_valid=1 exactly one cycle after 8th bit, for one cycle; overflow=0.
- Same 0xA5 word with sin_valid low on alternating cycles, plus 5 junk bits without sync sent before it in HUNT -> junk ignored, out_data=0xA5, out_valid one cycle after last accepted bit.
- Backpressure: out_ready=0, send 0x3C then 0xC3 back-to-back (one sync) -> out_data stays 0x3C and overflow=1 after the 0xC3 completion. Raise out_ready -> one transfer of 0x3C, then out_valid=0. ovf_clr -> overflow=0.
- Simultaneous: out_valid=1 with 0x11, out_ready=1 on the same cycle 0x22 completes -> 0x11 consumed, out_data=0x22 and out_valid=1 next cycle, overflow=0.
- Resync: sync, 3 bits, then sync + 0x5A -> frame_err high for exactly 1 cycle, out_data=0x5A, no word emitted for the partial bits.
- Async rst asserted after 4 bits with out_valid=1 -> all outputs 0 immediately. After release, bits without sync are ignored (FREE_RUN=0). With FREE_RUN=1, 8 bits immediately after release form a word.
